fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the next-generation (pipelined) RV32I core.
- Replaces the single-cycle PC register, +4 adder and combinational instruction-memory read.
- Owns the fetch PC and issues requests over a valid/ack handshake to instruction memory, so memory may take any number of cycles.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO for decode, and flushes on branch/jump redirect from execute.

Parameters:
XLEN, 32, data and address width in bits.
DEPTH, 4, FIFO entries; any integer >= 2.
RESET_PC, 32'h0000_0000, fetch PC loaded by reset.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_reset  input  1  asynchronous, active-high reset.
o_imem_req  output  1  fetch request valid.
o_imem_addr  output  XLEN  fetch address, word-aligned.
i_imem_ack  input  1  memory accepts the request; i_imem_rdata is valid in the same cycle.
i_imem_rdata  input  XLEN  instruction word.
i_redirect_vld  input  1  redirect pulse from execute (taken branch, jal, jalr).
i_redirect_pc  input  XLEN  redirect target.
o_inst_vld  output  1  FIFO head is valid.
o_inst  output  XLEN  head instruction.
o_inst_pc  output  XLEN  PC of the head instruction.
i_inst_rdy  input  1  decode consumes the head.
o_count  output  $clog2(DEPTH)+1  current occupancy.
o_full  output  1  o_count == DEPTH.
o_empty  output  1  o_count == 0.

Behaviour:
- Reset, asynchronous, effective immediately and mid-operation:
  - fetch_pc = RESET_PC; read/write pointers = 0; count = 0.
  - o_inst_vld = 0, o_imem_req = 0, o_empty = 1, o_full = 0.
  - o_inst and o_inst_pc read 0.
- Request generation (combinational):
  - o_imem_req = !i_reset && !i_redirect_vld && (count < DEPTH).
  - o_imem_addr = fetch_pc.
  - A full FIFO never requests, even while a pop is occurring.
- Accept: a cycle with o_imem_req && i_imem_ack.
  - Push {fetch_pc, i_imem_rdata} at the write pointer.
  - fetch_pc += 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x0).
  - The pushed entry is visible at the head no earlier than the next cycle; there is no bypass.
- Waiting: while o_imem_req is high and i_imem_ack is low, o_imem_addr is held stable.
  - Memory must tolerate req dropping without an ack; this happens only on redirect and is treated as an abort.
- Pop: a cycle with o_inst_vld && i_inst_rdy advances the read pointer.
  - o_inst_vld = (count != 0) && !i_redirect_vld.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap from DEPTH-1 to 0 using an explicit compare, so non-power-of-two DEPTH is legal.
- Redirect (highest priority):
  - In the cycle i_redirect_vld = 1: no push, no pop, and the memory response is discarded.
  - Next edge: pointers = 0, count = 0, fetch_pc = {i_redirect_pc[XLEN-1:2], 2'b00}. Low two bits are silently cleared.
  - Fetching resumes from the new PC in the following cycle.
  - Back-to-back redirects: the last one wins.
- Latency:
  - Request to head-valid is 1 cycle with zero-wait memory.
  - Steady-state throughput is one instruction per cycle while count < DEPTH and decode is ready.
- Order: instructions leave in strict program order between redirects. An entry is never duplicated or dropped except by redirect or reset.
- o_count, o_full and o_empty are derived from registered state only.

Test Plan:
1. DEPTH=4, RESET_PC=0, ack tied 1, rdy=0, memory returns inst = addr ^ 0xA5A5A5A5 -> requests 0x0, 0x4, 0x8, 0xC in 4 consecutive cycles; then o_full=1, o_count=4, o_imem_req=0.
2. Continue from 1 with rdy=1 -> heads pop as pc 0x0, 0x4, 0x8, 0xC with matching inst; refills start at 0x10; from then on one instruction per cycle with no gaps.
3. At count=3, i_redirect_vld=1 and i_redirect_pc=0x100 -> o_inst_vld=0 in that cycle; next cycle count=0 and o_imem_addr=0x100; subsequent heads are 0x100, 0x104; no stale 0x1x entries appear.
4. i_redirect_pc=0x203 -> next fetch address is 0x200.
5. Ack delayed 3 cycles per request -> o_imem_addr is held constant for 3 cycles, nothing is pushed until ack, and count increments exactly once per ack.
6. RESET_PC=0xFFFFFFFC; or assert i_reset asynchronously mid-cycle with count=2 -> first case: fetches 0xFFFFFFFC then 0x00000000; second case: o_inst_vld, o_imem_req and o_count drop to 0 before the next edge, and fetch restarts at RESET_PC after reset is released.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch front end: owns the fetch PC, issues
// valid/ack memory requests and buffers {pc, inst} pairs in a FIFO for decode.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  output logic                    o_imem_req,
  output logic [XLEN-1:0]         o_imem_addr,
  input  logic                    i_imem_ack,
  input  logic [XLEN-1:0]         i_imem_rdata,
  input  logic                    i_redirect_vld,
  input  logic [XLEN-1:0]         i_redirect_pc,
  output logic                    o_inst_vld,
  output logic [XLEN-1:0]         o_inst,
  output logic [XLEN-1:0]         o_inst_pc,
  input  logic                    i_inst_rdy,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic push;
  logic pop;

  assign o_imem_req  = !i_reset && !i_redirect_vld && (count_q < CW'(DEPTH));
  assign o_imem_addr = fetch_pc_q;
  assign push        = o_imem_req && i_imem_ack;
  assign o_inst_vld  = (count_q != '0) && !i_redirect_vld;
  assign pop         = o_inst_vld && i_inst_rdy;

  // Head reads zero when empty so reset and post-redirect outputs are clean.
  assign o_inst    = (count_q != '0) ? inst_mem[rptr_q] : '0;
  assign o_inst_pc = (count_q != '0) ? pc_mem[rptr_q]   : '0;
  assign o_count   = count_q;
  assign o_full    = (count_q == CW'(DEPTH));
  assign o_empty   = (count_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (i_redirect_vld) begin
      fetch_pc_d = i_redirect_pc & ~XLEN'(3);
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        wptr_d     = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc_q <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[wptr_q] <= i_imem_rdata;
      pc_mem[wptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue
// against a queue-based model of the fetch/FIFO behaviour.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        inst_vld;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        rdy = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mq[$];
  logic [31:0] mpc = 32'h0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ K;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(ack), .i_imem_rdata(imem_rdata),
    .i_redirect_vld(redir), .i_redirect_pc(rpc),
    .o_inst_vld(inst_vld), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_inst_rdy(rdy), .o_count(count), .o_full(full), .o_empty(empty)
  );

  function automatic logic [102:0] obs_vec();
    return {imem_req, imem_addr, inst_vld, inst, inst_pc, count, full, empty};
  endfunction

  function automatic logic [102:0] exp_vec();
    logic        req, vld;
    logic [31:0] hi, hp;
    req = !redir && (mq.size() < DEPTH);
    vld = (mq.size() != 0) && !redir;
    hp  = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
    hi  = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
    return {req, mpc, vld, hi, hp, 3'(mq.size()), mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic drive(input logic a, input logic r, input logic d, input logic [31:0] p);
    @(negedge clk);
    ack = a; rdy = r; redir = d; rpc = p;
    #1;
  endtask

  task automatic advance();
    logic req, pop;
    req = !redir && (mq.size() < DEPTH);
    pop = (mq.size() != 0) && !redir && rdy;
    if (redir) begin
      mq.delete();
      mpc = rpc & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (req && ack) begin
        mq.push_back({mpc, mpc ^ K});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({imem_req, inst_vld, count, empty, full, inst, inst_pc} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b vld=%b cnt=%0d e=%b f=%b inst=%h pc=%h want 0,0,0,1,0,0,0",
               imem_req, inst_vld, count, empty, full, inst, inst_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL fill c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if ({full, count, imem_req} !== {1'b1, 3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_full: got f=%b cnt=%0d req=%b want 1,4,0", full, count, imem_req);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      vectors++;
      if (obs_vec() !== exp_vec() || inst_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL stream c%0d: got %h vld=%b want %h vld=1", i, obs_vec(), inst_vld, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b0, 1'b1, 32'h40);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b1, 1'b1, 1'b1, 32'h100);
    vectors++;
    if (inst_vld !== 1'b0 || imem_req !== 1'b0 || count !== 3'd3) begin
      miscompares++;
      $display("FAIL redir_cycle: got vld=%b req=%b cnt=%0d want 0,0,3", inst_vld, imem_req, count);
    end
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      vectors++;
      if (obs_vec() !== exp_vec() || (i == 0 && {imem_addr, count} !== {32'h100, 3'd0})) begin
        miscompares++;
        $display("FAIL redir_after c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 1'b1, 32'h203);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (imem_addr !== 32'h200 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL misaligned: got addr=%h want 200", imem_addr);
    end
    advance();
  endtask

  task automatic test_wait();
    logic [31:0] held;
    drive(1'b0, 1'b0, 1'b1, 32'h300);
    advance();
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 4; w++) begin
        drive(w == 3, 1'b0, 1'b0, 32'h0);
        if (w == 0) held = 32'h300 + 32'(n * 4);
        vectors++;
        if (obs_vec() !== exp_vec() || imem_addr !== held || count !== 3'(n)) begin
          miscompares++;
          $display("FAIL wait n%0d w%0d: got addr=%h cnt=%0d want addr=%h cnt=%0d", n, w, imem_addr, count, held, n);
        end
        advance();
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      vectors++;
      if (obs_vec() !== exp_vec() || imem_addr !== 32'hFFFF_FFF8 + 32'(i * 4)) begin
        miscompares++;
        $display("FAIL wrap c%0d: got addr=%h want %h", i, imem_addr, 32'hFFFF_FFF8 + 32'(i * 4));
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h500);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (count !== 3'd2 || inst_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre: got cnt=%0d vld=%b want 2,1", count, inst_vld);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({inst_vld, imem_req, count, empty} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_mid: got vld=%b req=%b cnt=%0d e=%b want 0,0,0,1", inst_vld, imem_req, count, empty);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (imem_addr !== 32'h0 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL async_restart: got addr=%h want 0", imem_addr);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0), $urandom);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_redirect();
    test_misaligned();
    test_wait();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
